// File: rtl/sprite_char_engine_pkg.sv
// Shared types and helpers for the character sprite engine: facing codes,
// draw-sequencer states, command decode and the sprite-sheet address width.
package sprite_char_engine_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } facing_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_INIT   = 3'd1,
        CMD_ATTACK = 3'd2,
        CMD_UP     = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_LEFT   = 3'd5,
        CMD_RIGHT  = 3'd6
    } cmd_t;

    // Sheet is four facings wide and FRAMES walk rows plus one attack row tall.
    function automatic int sheet_addr_w(input int spr_w, input int spr_h, input int frames);
        return $clog2(4 * spr_w * (frames + 1) * spr_h);
    endfunction

endpackage

// File: rtl/sprite_char_engine_if.sv
// Command, sprite-ROM, frame-buffer and status signals of the sprite engine.
// master = game control / frame-buffer side, slave = the engine.
interface sprite_char_engine_if #(
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 3
);
    logic               init;
    logic               move_up;
    logic               move_down;
    logic               move_left;
    logic               move_right;
    logic               attack;
    logic               draw_start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [7:0]         x_draw;
    logic [7:0]         y_draw;
    logic [COLOR_W-1:0] color;
    logic               vga_write;
    logic               busy;
    logic               draw_done;
    logic [7:0]         pos_x;
    logic [7:0]         pos_y;
    logic [1:0]         facing;

    modport master (
        output init, move_up, move_down, move_left, move_right, attack, draw_start, rom_data,
        input  rom_addr, x_draw, y_draw, color, vga_write, busy, draw_done, pos_x, pos_y, facing
    );

    modport slave (
        input  init, move_up, move_down, move_left, move_right, attack, draw_start, rom_data,
        output rom_addr, x_draw, y_draw, color, vga_write, busy, draw_done, pos_x, pos_y, facing
    );

endinterface

// File: rtl/sprite_char_engine_addr_gen.sv
// Pixel counter and sprite-sheet address generation. The address is only
// driven while advancing so the ROM bus rests at zero between draws.
module sprite_addr_gen
    import sprite_char_engine_pkg::*;
#(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int FRAMES = 2,
    parameter int ADDR_W = sheet_addr_w(SPR_W, SPR_H, FRAMES),
    parameter int PX_W   = $clog2(SPR_W),
    parameter int PY_W   = $clog2(SPR_H),
    parameter int POSE_W = $clog2(FRAMES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  facing_t           facing,
    input  logic [POSE_W-1:0] pose,
    output logic [PX_W-1:0]   px,
    output logic [PY_W-1:0]   py,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int CNT_W = PX_W + PY_W;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // Pixel counter, raster order; power-of-two sprite wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign px   = cnt[PX_W-1:0];
    assign py   = cnt[CNT_W-1:PX_W];
    assign last = (cnt == CNT_W'(SPR_W * SPR_H - 1));

    // Row = pose block plus line within sprite; column = facing block plus pixel.
    always_comb begin
        row  = ADDR_W'(pose) * ADDR_W'(SPR_H) + ADDR_W'(py);
        col  = ADDR_W'(facing) * ADDR_W'(SPR_W) + ADDR_W'(px);
        addr = '0;
        if (advance) begin
            addr = row * ADDR_W'(4 * SPR_W) + col;
        end
    end

endmodule

// File: rtl/sprite_char_engine.sv
// Character sprite engine: position/facing/animation state with edge
// clamping, and a draw sequencer streaming the sprite to the frame buffer.
//
//   state | meaning
//   IDLE  | accepting commands and draw_start
//   DRAW  | issuing one sheet address per cycle
//   FLUSH | last pixel returning from the ROM
//   DONE  | draw_done pulse, attack pose released
module sprite_char_engine
    import sprite_char_engine_pkg::*;
#(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int MAP_W       = 256,
    parameter int MAP_H       = 176,
    parameter int STEP        = 1,
    parameter int FRAMES      = 2,
    parameter int INIT_X      = 120,
    parameter int INIT_Y      = 80,
    parameter int COLOR_W     = 3,
    parameter int TRANSPARENT = 0
) (
    input logic              clock,
    input logic              reset,
    sprite_char_engine_if.slave bus
);

    localparam int ADDR_W  = sheet_addr_w(SPR_W, SPR_H, FRAMES);
    localparam int PX_W    = $clog2(SPR_W);
    localparam int PY_W    = $clog2(SPR_H);
    localparam int POSE_W  = $clog2(FRAMES + 1);
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int X_MAX   = MAP_W - SPR_W;
    localparam int Y_MAX   = MAP_H - SPR_H;

    state_t              state_q;
    state_t              state_d;
    cmd_t                cmd;
    logic [7:0]          pos_x_q;
    logic [7:0]          pos_y_q;
    facing_t             facing_q;
    logic [FRAME_W-1:0]  frame_q;
    logic [FRAME_W-1:0]  frame_next;
    logic                attack_q;
    logic                cnt_clear;
    logic                cnt_advance;
    logic                cnt_last;
    logic                busy_c;
    logic                draw_done_c;
    logic [PX_W-1:0]     px;
    logic [PY_W-1:0]     py;
    logic [ADDR_W-1:0]   addr;
    logic [POSE_W-1:0]   pose;
    logic                pix_valid_q;
    logic [7:0]          x_q;
    logic [7:0]          y_q;

    // Single command per cycle, only when idle, in fixed priority order.
    always_comb begin
        cmd = CMD_NONE;
        if (state_q == IDLE) begin
            if (bus.init)            cmd = CMD_INIT;
            else if (bus.attack)     cmd = CMD_ATTACK;
            else if (bus.move_up)    cmd = CMD_UP;
            else if (bus.move_down)  cmd = CMD_DOWN;
            else if (bus.move_left)  cmd = CMD_LEFT;
            else if (bus.move_right) cmd = CMD_RIGHT;
        end
    end

    assign frame_next = FRAME_W'((int'(frame_q) + 1) % FRAMES);

    // Position, facing, walk frame and attack pose.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            facing_q <= DOWN;
            frame_q  <= '0;
            attack_q <= 1'b0;
        end else begin
            if (state_q == DONE) begin
                attack_q <= 1'b0;
            end
            case (cmd)
                CMD_INIT: begin
                    pos_x_q  <= 8'(INIT_X);
                    pos_y_q  <= 8'(INIT_Y);
                    facing_q <= DOWN;
                    frame_q  <= '0;
                    attack_q <= 1'b0;
                end
                CMD_ATTACK: attack_q <= 1'b1;
                CMD_UP: begin
                    facing_q <= UP;
                    pos_y_q  <= (int'(pos_y_q) < STEP) ? 8'd0 : pos_y_q - 8'(STEP);
                    frame_q  <= frame_next;
                    attack_q <= 1'b0;
                end
                CMD_DOWN: begin
                    facing_q <= DOWN;
                    pos_y_q  <= (int'(pos_y_q) + STEP > Y_MAX) ? 8'(Y_MAX) : pos_y_q + 8'(STEP);
                    frame_q  <= frame_next;
                    attack_q <= 1'b0;
                end
                CMD_LEFT: begin
                    facing_q <= LEFT;
                    pos_x_q  <= (int'(pos_x_q) < STEP) ? 8'd0 : pos_x_q - 8'(STEP);
                    frame_q  <= frame_next;
                    attack_q <= 1'b0;
                end
                CMD_RIGHT: begin
                    facing_q <= RIGHT;
                    pos_x_q  <= (int'(pos_x_q) + STEP > X_MAX) ? 8'(X_MAX) : pos_x_q + 8'(STEP);
                    frame_q  <= frame_next;
                    attack_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Draw sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Draw sequencer next state and control.
    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        busy_c      = 1'b1;
        draw_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.draw_start) begin
                    state_d   = DRAW;
                    cnt_clear = 1'b1;
                end
            end
            DRAW: begin
                cnt_advance = 1'b1;
                if (cnt_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
                draw_done_c = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pose = attack_q ? POSE_W'(FRAMES) : POSE_W'(frame_q);

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .FRAMES (FRAMES),
        .ADDR_W (ADDR_W),
        .PX_W   (PX_W),
        .PY_W   (PY_W),
        .POSE_W (POSE_W)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .facing  (facing_q),
        .pose    (pose),
        .px      (px),
        .py      (py),
        .addr    (addr),
        .last    (cnt_last)
    );

    // Output stage: coordinates and valid flag line up with the ROM's one-cycle latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            pix_valid_q <= cnt_advance;
            if (cnt_advance) begin
                x_q <= pos_x_q + 8'(px);
                y_q <= pos_y_q + 8'(py);
            end
        end
    end

    assign bus.rom_addr  = addr;
    assign bus.x_draw    = x_q;
    assign bus.y_draw    = y_q;
    assign bus.color     = pix_valid_q ? bus.rom_data : '0;
    assign bus.vga_write = pix_valid_q && (bus.rom_data != COLOR_W'(TRANSPARENT));
    assign bus.busy      = busy_c;
    assign bus.draw_done = draw_done_c;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.facing    = facing_q;

endmodule

// File: tb/tb_sprite_char_engine.sv
// Self-checking bench for sprite_char_engine against a behavioural model of
// the character state and the expected draw stream.
module tb_sprite_char_engine;
    import sprite_char_engine_pkg::*;

    localparam int SPR_W  = 16;
    localparam int SPR_H  = 16;
    localparam int MAP_W  = 256;
    localparam int MAP_H  = 176;
    localparam int STEP   = 1;
    localparam int FRAMES = 2;
    localparam int INIT_X = 120;
    localparam int INIT_Y = 80;
    localparam int N      = SPR_W * SPR_H;
    localparam int ADDR_W = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sprite_char_engine_if #(.ADDR_W(ADDR_W), .COLOR_W(3)) bus();

    sprite_char_engine #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .MAP_W(MAP_W), .MAP_H(MAP_H), .STEP(STEP),
        .FRAMES(FRAMES), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .COLOR_W(3), .TRANSPARENT(0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [2:0] rom [0:4095];
    always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

    int n_vec = 0;
    int n_err = 0;
    int m_x, m_y, m_face, m_frame, m_att;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        bus.init = 0; bus.attack = 0; bus.move_up = 0; bus.move_down = 0;
        bus.move_left = 0; bus.move_right = 0; bus.draw_start = 0;
    endtask

    task automatic model_reset;
        m_x = 0; m_y = 0; m_face = 1; m_frame = 0; m_att = 0;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_move(input int face, input int dx, input int dy);
        m_face  = face;
        m_x     = clamp(m_x + dx, 0, MAP_W - SPR_W);
        m_y     = clamp(m_y + dy, 0, MAP_H - SPR_H);
        m_frame = (m_frame + 1) % FRAMES;
        m_att   = 0;
    endtask

    task automatic model_cmd(input bit i, input bit a, input bit u, input bit d, input bit l, input bit r);
        if (i) begin m_x = INIT_X; m_y = INIT_Y; m_face = 1; m_frame = 0; m_att = 0; end
        else if (a) m_att = 1;
        else if (u) model_move(0, 0, -STEP);
        else if (d) model_move(1, 0, STEP);
        else if (l) model_move(2, -STEP, 0);
        else if (r) model_move(3, STEP, 0);
    endtask

    function automatic int exp_addr(input int c);
        int px, py, pose;
        px   = c % SPR_W;
        py   = c / SPR_W;
        pose = m_att ? FRAMES : m_frame;
        return (pose * SPR_H + py) * (4 * SPR_W) + m_face * SPR_W + px;
    endfunction

    task automatic check_state(input string tag);
        n_vec++;
        if (bus.pos_x !== 8'(m_x)) begin
            n_err++; $display("FAIL %s pos_x got %0d want %0d", tag, bus.pos_x, m_x);
        end
        n_vec++;
        if (bus.pos_y !== 8'(m_y)) begin
            n_err++; $display("FAIL %s pos_y got %0d want %0d", tag, bus.pos_y, m_y);
        end
        n_vec++;
        if (bus.facing !== 2'(m_face)) begin
            n_err++; $display("FAIL %s facing got %0d want %0d", tag, bus.facing, m_face);
        end
    endtask

    task automatic cmd_cycle(input bit i, input bit a, input bit u, input bit d, input bit l, input bit r);
        bus.init = i; bus.attack = a; bus.move_up = u;
        bus.move_down = d; bus.move_left = l; bus.move_right = r;
        tick();
        clear_inputs();
        model_cmd(i, a, u, d, l, r);
        check_state("cmd");
    endtask

    task automatic fill_rom_random;
        for (int k = 0; k < 4096; k++) rom[k] = 3'($urandom_range(0, 7));
    endtask

    // One draw from IDLE; poke drives move_up/draw_start mid-draw, abort_cyc>0 resets at that cycle.
    task automatic run_draw(input bit poke, input int abort_cyc, output int writes, output int bad_hits);
        int a, px, py;
        logic [2:0] d;
        logic exp_we;
        writes   = 0;
        bad_hits = 0;
        bus.draw_start = 1;
        tick();
        bus.draw_start = 0;
        for (int cyc = 1; cyc <= N + 3; cyc++) begin
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                reset = 1;
                tick();
                reset = 0;
                model_reset();
                for (int k = 0; k < 20; k++) begin
                    n_vec++;
                    if (bus.vga_write !== 1'b0 || bus.draw_done !== 1'b0 || bus.busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort k=%0d we=%b done=%b busy=%b want 0", k, bus.vga_write, bus.draw_done, bus.busy);
                    end
                    tick();
                end
                check_state("abort");
                return;
            end
            n_vec++;
            if (bus.busy !== (cyc <= N + 2)) begin
                n_err++; $display("FAIL busy cyc=%0d got %b want %b", cyc, bus.busy, cyc <= N + 2);
            end
            if (cyc <= N) begin
                n_vec++;
                if (bus.rom_addr !== 12'(exp_addr(cyc - 1))) begin
                    n_err++; $display("FAIL rom_addr cyc=%0d got %0d want %0d", cyc, bus.rom_addr, exp_addr(cyc - 1));
                end
            end
            if (cyc >= 2 && cyc <= N + 1) begin
                a  = exp_addr(cyc - 2);
                px = (cyc - 2) % SPR_W;
                py = (cyc - 2) / SPR_W;
                d  = rom[a];
                exp_we = (d != 3'd0);
                n_vec++;
                if (bus.vga_write !== exp_we) begin
                    n_err++; $display("FAIL vga_write cyc=%0d got %b want %b", cyc, bus.vga_write, exp_we);
                end
                if (exp_we) begin
                    n_vec++;
                    if (bus.x_draw !== 8'(m_x + px) || bus.y_draw !== 8'(m_y + py) || bus.color !== d) begin
                        n_err++;
                        $display("FAIL pixel cyc=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                 cyc, bus.x_draw, bus.y_draw, bus.color, m_x + px, m_y + py, d);
                    end
                end
            end else begin
                n_vec++;
                if (bus.vga_write !== 1'b0) begin
                    n_err++; $display("FAIL vga_write_idle cyc=%0d got %b want 0", cyc, bus.vga_write);
                end
            end
            if (bus.vga_write === 1'b1) begin
                writes++;
                if (bus.x_draw == 8'(m_x + 3) && bus.y_draw == 8'(m_y + 2)) bad_hits++;
            end
            n_vec++;
            if (bus.draw_done !== (cyc == N + 2)) begin
                n_err++; $display("FAIL draw_done cyc=%0d got %b want %b", cyc, bus.draw_done, cyc == N + 2);
            end
            if (poke && cyc >= 3 && cyc <= 6) begin
                bus.move_up = 1; bus.draw_start = 1;
            end else begin
                bus.move_up = 0; bus.draw_start = 0;
            end
            tick();
        end
        clear_inputs();
        m_att = 0;
        check_state("post_draw");
    endtask

    task automatic test_reset;
        clear_inputs();
        fill_rom_random();
        reset = 1;
        tick(); tick(); tick();
        model_reset();
        check_state("reset");
        n_vec++;
        if (bus.busy !== 0 || bus.vga_write !== 0 || bus.draw_done !== 0 || bus.x_draw !== 0 ||
            bus.y_draw !== 0 || bus.color !== 0 || bus.rom_addr !== 0) begin
            n_err++;
            $display("FAIL reset_outputs busy=%b we=%b done=%b x=%0d y=%0d col=%0d addr=%0d want all 0",
                     bus.busy, bus.vga_write, bus.draw_done, bus.x_draw, bus.y_draw, bus.color, bus.rom_addr);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_init;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.pos_x !== 8'd120 || bus.pos_y !== 8'd80 || bus.facing !== 2'd1 ||
            bus.busy !== 0 || bus.vga_write !== 0) begin
            n_err++;
            $display("FAIL init got (%0d,%0d,f%0d,b%b,w%b) want (120,80,f1,b0,w0)",
                     bus.pos_x, bus.pos_y, bus.facing, bus.busy, bus.vga_write);
        end
    endtask

    task automatic test_move_left_draw;
        int w, b;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cmd_cycle(0, 0, 0, 0, 1, 0);
        n_vec++;
        if (bus.pos_x !== 8'd117 || bus.facing !== 2'd2 || m_frame != 1) begin
            n_err++; $display("FAIL move_left got x=%0d f=%0d want x=117 f=2", bus.pos_x, bus.facing);
        end
        fill_rom_random();
        run_draw(0, 0, w, b);
    endtask

    task automatic test_clamp;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        repeat (121) cmd_cycle(0, 0, 0, 0, 1, 0);
        n_vec++;
        if (bus.pos_x !== 8'd0) begin n_err++; $display("FAIL clamp_left got %0d want 0", bus.pos_x); end
        repeat (241) cmd_cycle(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (bus.pos_x !== 8'd240) begin n_err++; $display("FAIL clamp_right got %0d want 240", bus.pos_x); end
        repeat (81) cmd_cycle(0, 0, 0, 1, 0, 0);
        n_vec++;
        if (bus.pos_y !== 8'd160) begin n_err++; $display("FAIL clamp_down got %0d want 160", bus.pos_y); end
        repeat (161) cmd_cycle(0, 0, 1, 0, 0, 0);
        n_vec++;
        if (bus.pos_y !== 8'd0) begin n_err++; $display("FAIL clamp_up got %0d want 0", bus.pos_y); end
    endtask

    task automatic test_transparent;
        int w, b;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4096; k++) rom[k] = 3'd5;
        rom[(2 * (4 * SPR_W)) + SPR_W + 3] = 3'd0;
        run_draw(0, 0, w, b);
        n_vec++;
        if (w != 255) begin n_err++; $display("FAIL transparent_count got %0d want 255", w); end
        n_vec++;
        if (b != 0) begin n_err++; $display("FAIL transparent_hole got %0d writes want 0", b); end
    endtask

    task automatic test_attack;
        int w, b;
        fill_rom_random();
        cmd_cycle(0, 1, 0, 0, 0, 0);
        run_draw(0, 0, w, b);
        run_draw(0, 0, w, b);
    endtask

    task automatic test_busy_ignore;
        int w, b;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        run_draw(1, 0, w, b);
        n_vec++;
        if (bus.pos_y !== 8'd80) begin n_err++; $display("FAIL busy_move got y=%0d want 80", bus.pos_y); end
    endtask

    task automatic test_reset_mid_draw;
        int w, b;
        cmd_cycle(1, 0, 0, 0, 0, 0);
        run_draw(0, 102, w, b);
    endtask

    task automatic test_random;
        int w, b;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 60; k++) begin
                cmd_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
            fill_rom_random();
            run_draw(0, 0, w, b);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_move_left_draw();
        test_clamp();
        test_transparent();
        test_attack();
        test_busy_ignore();
        test_reset_mid_draw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_char_engine.md
# sprite_char_engine

Parametrised character sprite engine for the map renderer. It holds one character's map position, facing, walk-animation frame and attack pose, applies single-step move/attack commands from the game control FSM with map-edge clamping, and streams the current sprite from a sprite-sheet ROM to the frame-buffer writer with transparency keying. It generalises the fixed 16x16, four-facing player block to any sprite size, map size, step size and walk-frame count, and adds animation, clamping and a busy/done handshake.

## Interface
- SPR_W, 16, sprite width in pixels (power of 2)
- SPR_H, 16, sprite height in pixels (power of 2)
- MAP_W, 256, map width in pixels
- MAP_H, 176, map height in pixels
- STEP, 1, pixels moved per accepted move command
- FRAMES, 2, walk-animation frames per facing (power of 2)
- INIT_X, 120, position X loaded by init
- INIT_Y, 80, position Y loaded by init
- COLOR_W, 3, pixel colour width
- TRANSPARENT, 0, colour value that is never written
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- init  in  1  load INIT_X/INIT_Y, facing DOWN, frame 0, clear attack
- move_up, move_down, move_left, move_right  in  1 each  one-step move request
- attack  in  1  select the attack pose for the next draw
- draw_start  in  1  begin streaming the sprite
- rom_addr  out  log2(4*SPR_W*(FRAMES+1)*SPR_H)  sprite-sheet read address
- rom_data  in  COLOR_W  ROM pixel, valid 1 cycle after rom_addr
- x_draw, y_draw  out  8 each  frame-buffer pixel coordinate
- color  out  COLOR_W  pixel colour
- vga_write  out  1  pixel write strobe
- busy  out  1  high while a draw is in progress
- draw_done  out  1  one-cycle pulse when the draw completes
- pos_x, pos_y  out  8 each  current top-left position
- facing  out  2  UP=0, DOWN=1, LEFT=2, RIGHT=3

## Operation
- Reset: pos = 0,0; facing = DOWN; frame = 0; attack_pose = 0; FSM IDLE. All outputs are 0 except facing = 1.
- Commands are accepted only in IDLE and ignored while busy. Priority: init > attack > up > down > left > right. At most one command is accepted per cycle.
- Move: set facing, then step pos by STEP, clamped to 0..MAP_W-SPR_W (X) or 0..MAP_H-SPR_H (Y). Subtraction never wraps; a move at an edge clamps to the edge. frame increments modulo FRAMES on every accepted move, including clamped moves. attack_pose is cleared.
- Attack: attack_pose = 1. Position, facing and frame are unchanged.
- Sheet layout: the column block is facing*SPR_W. The row block is pose*SPR_H, where pose = attack_pose ? FRAMES : frame. rom_addr = (row_block+py)*(4*SPR_W) + col_block + px.
- FSM states:
  - IDLE: on draw_start, go to DRAW and clear pixel counter c.
  - DRAW: issue the address for pixel c (px = c mod SPR_W, py = c / SPR_W). c increments every cycle. After c = SPR_W*SPR_H-1, go to FLUSH.
  - FLUSH: present the last pixel, go to DONE.
  - DONE: pulse draw_done, clear attack_pose, go to IDLE.
- Output stage is registered. Pixel c appears one cycle after its address: x_draw = pos_x+px, y_draw = pos_y+py, color = rom_data, vga_write = (rom_data != TRANSPARENT).
- draw_start while busy is ignored.

## Timing
- draw_start sampled at cycle 0. busy is high from cycles 1 to N+2, where N = SPR_W*SPR_H.
- Addresses are issued in cycles 1..N. Pixel writes occur in cycles 2..N+1. draw_done is high in cycle N+2 only.
- Total draw latency is N+2 cycles; the next draw_start is accepted in cycle N+3.
- vga_write is never high outside cycles 2..N+1.
- Moves take effect the cycle after acceptance and are visible on pos_x/pos_y.
- Reset mid-draw aborts immediately: vga_write and draw_done drop next cycle, no partial done pulse.

## Structure
- Shared package: facing encodings UP/DOWN/LEFT/RIGHT, FSM state enum, and the sheet-address width function.
- One sub-module, sprite_addr_gen: pixel counter plus px/py/rom_addr computation.
- Position, animation and output stage stay in the top module.

## Test plan
- Reset then init → pos 120,80, facing 1, frame 0, busy 0, vga_write 0.
- init, move_left ×3 → pos_x 117, facing 2, frame 1. A draw then reads row block 16 and column block 32.
- pos_x=0, move_left → pos_x stays 0. pos_x=240, move_right → stays 240. pos_y=160, move_down → stays 160.
- ROM all 5 except pixel (3,2) = 0, draw at 120,80 → 255 writes in cycles 2..257, none at (123,82), draw_done pulse at cycle 258.
- attack then draw → addresses use row block 32 (pose FRAMES). Second draw reverts to walk row.
- move_up and draw_start during busy → no position change, no restart. Reset at pixel 100 → no further writes, no draw_done.
